// File: rtl/cmd_decoder_pkg.sv
// la_cmd_pkg: shared definitions for the command decoder.
// Holds the opcode high-nibble codes, the decoder state encoding and the
// default resync byte. Imported by cmd_decoder and cmd_gap_timer.
package la_cmd_pkg;

    // Opcode high-nibble command codes (Order[7:4])
    localparam logic [3:0] OP_CLRALL  = 4'hF;
    localparam logic [3:0] OP_ADDEN   = 4'hE;
    localparam logic [3:0] OP_INIT    = 4'hD;
    localparam logic [3:0] OP_TRIG_ON = 4'hC;
    localparam logic [3:0] OP_TRIG_OF = 4'hB;
    localparam logic [3:0] OP_SETTRIG = 4'hA;
    localparam logic [3:0] OP_RELOAD  = 4'h9;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_EXEC    = 2'd3
    } state_t;

endpackage

// File: rtl/cmd_gap_timer.sv
// cmd_gap_timer: counts idle cycles inside a frame.
// Ports:
//   clk      - clock, rising edge
//   clr      - synchronous active-high reset
//   clear    - restart the count at zero (byte accepted / not in a frame)
//   enable   - count this cycle
//   expired  - count has reached TIMEOUT (held until cleared)
module cmd_gap_timer import la_cmd_pkg::*; #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (clr || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            // saturate at the limit so expired stays asserted until cleared
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/cmd_decoder.sv
// cmd_decoder: byte-stream command frame decoder.
// A frame is an opcode byte followed by PAYLOAD_BYTES payload bytes; the
// opcode high nibble selects a one-cycle command strobe. A SYNC byte aborts
// any partial frame. A stalled frame is dropped after TIMEOUT idle cycles.
// Optional feature macro: CMD_DECODER_CKSUM_EN adds a trailing checksum byte
// (XOR of opcode and payload) that must match before the frame executes.
// Ports:
//   CLK, CLR          - clock, synchronous active-high reset
//   DataIn, DataValid - received byte and its qualifier
//   Locked            - PLL lock status (forces SetInit while low)
//   Order, Data       - last executed opcode and payload (byte 0 in LSBs)
//   adden, SetTrigTime, SoftReload, ClrAll - one-cycle command strobes
//   SetInit           - init strobe OR not Locked
//   TrigEN            - trigger enable level
//   CmdErr            - one-cycle frame error strobe
module cmd_decoder import la_cmd_pkg::*; #(
    parameter int            DW            = 8,
    parameter int            PAYLOAD_BYTES = 1,
    parameter logic [DW-1:0] SYNC          = DW'(SYNC_DEFAULT),
    parameter int            TIMEOUT       = 1024
) (
    input  logic                        CLK,
    input  logic                        CLR,
    input  logic [DW-1:0]               DataIn,
    input  logic                        DataValid,
    input  logic                        Locked,
    output logic [DW-1:0]               Order,
    output logic [PAYLOAD_BYTES*DW-1:0] Data,
    output logic                        adden,
    output logic                        SetTrigTime,
    output logic                        SoftReload,
    output logic                        ClrAll,
    output logic                        SetInit,
    output logic                        TrigEN,
    output logic                        CmdErr
);

    localparam int IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);

    state_t                     state;
    logic [DW-1:0]              opcode_q;
    logic [PAYLOAD_BYTES*DW-1:0] pay_q;
    logic [PAYLOAD_BYTES*DW-1:0] pay_next;
    logic [PAYLOAD_BYTES*DW-1:0] exec_data;
    logic [IW-1:0]              idx;
    logic                       init_q;
    logic                       is_sync;
    logic                       in_frame;
    logic                       last_byte;
    logic                       exec_go;
    logic                       expired;
`ifdef CMD_DECODER_CKSUM_EN
    logic [DW-1:0]              cks_q;
`endif

    always_comb begin
        is_sync   = DataValid && (DataIn == SYNC);
        in_frame  = (state == ST_PAYLOAD) || (state == ST_CHECK);
        last_byte = (idx == LAST_IDX);
        // payload including the byte on the bus, so the final byte can be
        // published in the same edge that enters EXEC
        pay_next  = pay_q;
        pay_next[idx*DW +: DW] = DataIn;
        exec_go   = 1'b0;
        exec_data = pay_next;
        if (DataValid && !is_sync) begin
`ifdef CMD_DECODER_CKSUM_EN
            if ((state == ST_CHECK) && (DataIn == cks_q)) begin
                exec_go   = 1'b1;
                exec_data = pay_q;
            end
`else
            if ((state == ST_PAYLOAD) && last_byte) begin
                exec_go = 1'b1;
            end
`endif
        end
    end

    cmd_gap_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_gap_timer (
        .clk    (CLK),
        .clr    (CLR),
        .clear  (!in_frame || DataValid),
        .enable (in_frame),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state       <= ST_IDLE;
            idx         <= '0;
            Order       <= '0;
            Data        <= '0;
            adden       <= 1'b0;
            SetTrigTime <= 1'b0;
            SoftReload  <= 1'b0;
            ClrAll      <= 1'b0;
            init_q      <= 1'b0;
            TrigEN      <= 1'b1;
            CmdErr      <= 1'b0;
        end else begin
            adden       <= 1'b0;
            SetTrigTime <= 1'b0;
            SoftReload  <= 1'b0;
            ClrAll      <= 1'b0;
            init_q      <= 1'b0;
            CmdErr      <= 1'b0;
            if (is_sync) begin
                state <= ST_IDLE;
            end else if (exec_go) begin
                // strobes are registered here so they are high during EXEC
                state <= ST_EXEC;
                Order <= opcode_q;
                Data  <= exec_data;
                case (opcode_q[7:4])
                    OP_CLRALL:  ClrAll      <= 1'b1;
                    OP_ADDEN:   adden       <= 1'b1;
                    OP_INIT:    init_q      <= 1'b1;
                    OP_TRIG_ON: TrigEN      <= 1'b1;
                    OP_TRIG_OF: TrigEN      <= 1'b0;
                    OP_SETTRIG: SetTrigTime <= 1'b1;
                    OP_RELOAD:  SoftReload  <= 1'b1;
                    default:    CmdErr      <= 1'b1;
                endcase
            end else if (DataValid) begin
                case (state)
                    ST_PAYLOAD: begin
                        pay_q <= pay_next;
`ifdef CMD_DECODER_CKSUM_EN
                        cks_q <= cks_q ^ DataIn;
`endif
                        if (!last_byte) idx <= idx + 1'b1;
`ifdef CMD_DECODER_CKSUM_EN
                        else            state <= ST_CHECK;
`endif
                    end
                    ST_CHECK: begin
                        // checksum mismatch: drop the frame
                        state  <= ST_IDLE;
                        CmdErr <= 1'b1;
                    end
                    default: begin
                        // IDLE or EXEC: this byte opens a new frame
                        opcode_q <= DataIn;
                        idx      <= '0;
                        state    <= ST_PAYLOAD;
`ifdef CMD_DECODER_CKSUM_EN
                        cks_q    <= DataIn;
`endif
                    end
                endcase
            end else if (in_frame && expired) begin
                state  <= ST_IDLE;
                CmdErr <= 1'b1;
            end else if (state == ST_EXEC) begin
                state <= ST_IDLE;
            end
        end
    end

    assign SetInit = init_q | ~Locked;

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed testbench for cmd_decoder (PAYLOAD_BYTES=1, TIMEOUT=16).
// Works with or without CMD_DECODER_CKSUM_EN; frames carry a checksum byte
// when the macro is defined.
module tb_cmd_decoder;

    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic          CLK = 1'b0;
    logic          CLR = 1'b1;
    logic [DW-1:0] DataIn = '0;
    logic          DataValid = 1'b0;
    logic          Locked = 1'b1;
    logic [DW-1:0] Order;
    logic [DW-1:0] Data;
    logic          adden, SetTrigTime, SoftReload, ClrAll, SetInit, TrigEN, CmdErr;

    int n_checks = 0;
    int n_errors = 0;

    cmd_decoder #(
        .DW(DW), .PAYLOAD_BYTES(1), .SYNC(8'hA5), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .CLR(CLR), .DataIn(DataIn), .DataValid(DataValid),
        .Locked(Locked), .Order(Order), .Data(Data), .adden(adden),
        .SetTrigTime(SetTrigTime), .SoftReload(SoftReload), .ClrAll(ClrAll),
        .SetInit(SetInit), .TrigEN(TrigEN), .CmdErr(CmdErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // byte presented from the falling edge, accepted on the next rising
    // edge; outputs are sampled 1 time unit after that edge
    task automatic send_byte(input logic [DW-1:0] b);
        @(negedge CLK);
        DataIn    = b;
        DataValid = 1'b1;
        @(posedge CLK);
        #1;
        DataValid = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] op, input logic [DW-1:0] pl);
        send_byte(op);
        send_byte(pl);
`ifdef CMD_DECODER_CKSUM_EN
        send_byte(op ^ pl);
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // opcode / strobe table for the remaining command nibbles
    logic [7:0] tbl_op [3] = '{8'hF0, 8'hA0, 8'h90};

    initial begin
        int cnt;
        repeat (3) step();
        chk("rst_order",  32'(Order),  'h00);
        chk("rst_data",   32'(Data),   'h00);
        chk("rst_trigen", 32'(TrigEN), 1);
        chk("rst_adden",  32'(adden),  0);
        chk("rst_cmderr", 32'(CmdErr), 0);
        chk("rst_setinit", 32'(SetInit), 0);
        CLR = 1'b0;
        step();

        // basic adden frame
        send_frame(8'hE3, 8'h05);
        chk("e3_adden", 32'(adden),  1);
        chk("e3_order", 32'(Order),  'hE3);
        chk("e3_data",  32'(Data),   'h05);
        chk("e3_err",   32'(CmdErr), 0);
        step();
        chk("e3_adden_1cyc", 32'(adden), 0);

        // trigger enable off then on, back to back
        send_frame(8'hB0, 8'h00);
        chk("trig_off", 32'(TrigEN), 0);
        send_frame(8'hC0, 8'h00);
        chk("trig_on", 32'(TrigEN), 1);

        // SYNC aborts a partial frame; following init frame executes
        send_byte(8'hE3);
        send_byte(8'hA5);
        chk("sync_no_adden", 32'(adden), 0);
        send_frame(8'hD0, 8'h00);
        chk("init_setinit", 32'(SetInit), 1);
        chk("init_adden",   32'(adden),   0);
        chk("init_order",   32'(Order),   'hD0);
        step();
        chk("init_1cyc", 32'(SetInit), 0);
        Locked = 1'b0;
        #1;
        chk("unlocked_setinit", 32'(SetInit), 1);
        step();
        chk("unlocked_hold", 32'(SetInit), 1);
        Locked = 1'b1;

        // remaining strobes
        for (int i = 0; i < 3; i++) begin
            send_frame(tbl_op[i], 8'(i + 1));
            chk("tbl_clrall",  32'(ClrAll),      (i == 0) ? 1 : 0);
            chk("tbl_settrig", 32'(SetTrigTime), (i == 1) ? 1 : 0);
            chk("tbl_reload",  32'(SoftReload),  (i == 2) ? 1 : 0);
            chk("tbl_data",    32'(Data),        i + 1);
        end

        // gap timeout: opcode then silence; error after TIMEOUT+1 edges
        // (TIMEOUT counting edges, one more to act on the expired count)
        send_byte(8'hE3);
        cnt = 0;
        while (!CmdErr && cnt < 100) begin
            step();
            cnt++;
        end
        chk("timeout_cycles", cnt, TIMEOUT + 1);
        chk("timeout_order",  32'(Order), 'h90);
        step();
        chk("timeout_err_1cyc", 32'(CmdErr), 0);
        send_frame(8'hE1, 8'h02);
        chk("after_timeout_adden", 32'(adden), 1);
        chk("after_timeout_data",  32'(Data),  'h02);

        // unknown opcode nibble
        send_frame(8'h70, 8'h00);
        chk("bad_op_err",   32'(CmdErr), 1);
        chk("bad_op_adden", 32'(adden),  0);

        // CLR mid-frame: next byte is an opcode
        send_byte(8'hE3);
        @(negedge CLK);
        CLR = 1'b1;
        step();
        chk("clr_order", 32'(Order), 'h00);
        CLR = 1'b0;
        send_frame(8'h05, 8'h00);
        chk("clr_reopcode_err",   32'(CmdErr), 1);
        chk("clr_reopcode_adden", 32'(adden),  0);
        chk("clr_reopcode_order", 32'(Order),  'h05);

`ifdef CMD_DECODER_CKSUM_EN
        send_byte(8'hE3);
        send_byte(8'h05);
        send_byte(8'hE6);
        chk("cks_ok_adden", 32'(adden), 1);
        send_byte(8'hE3);
        send_byte(8'h07);
        send_byte(8'h00);
        chk("cks_bad_err",   32'(CmdErr), 1);
        chk("cks_bad_adden", 32'(adden),  0);
        chk("cks_bad_data",  32'(Data),   'h05);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmd_decoder.md
CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 Parameter DW, 8, byte width of DataIn and of each payload byte.
REQ-002 Parameter PAYLOAD_BYTES, 1, payload bytes per frame (1..4).
REQ-003 Parameter SYNC, 8'hA5, abort/resync byte value.
REQ-004 Parameter TIMEOUT, 1024, max CLK cycles between bytes inside a frame.
REQ-005 CLK  in  1  single clock, all logic on rising edge.
REQ-006 CLR  in  1  reset: synchronous, active-high.
REQ-007 DataIn  in  DW  received byte.
REQ-008 DataValid  in  1  DataIn qualifier, one byte per high cycle.
REQ-009 Locked  in  1  PLL lock status.
REQ-010 Order  out  DW  last executed opcode.
REQ-011 Data  out  PAYLOAD_BYTES*DW  last executed payload, byte 0 in LSBs.
REQ-012 adden, SetTrigTime, SoftReload, ClrAll  out  1 each  one-cycle command strobes.
REQ-013 SetInit  out  1  init-strobe OR NOT Locked.
REQ-014 TrigEN  out  1  trigger enable level.
REQ-015 CmdErr  out  1  one-cycle frame-error strobe.

Function
REQ-016 States: IDLE (await opcode), PAYLOAD (collect PAYLOAD_BYTES bytes), CHECK (macro only), EXEC (one cycle).
REQ-017 Byte accepted only when DataValid=1; DataValid=0 leaves state and counters unchanged except gap timer.
REQ-018 Accepted byte equal to SYNC in any state -> IDLE next cycle, byte discarded, no strobe, no CmdErr.
REQ-019 IDLE: accepted non-SYNC byte latched as opcode -> PAYLOAD, byte index cleared.
REQ-020 PAYLOAD: bytes stored in index order; after byte PAYLOAD_BYTES-1 -> CHECK (macro) or EXEC.
REQ-021 Order and Data update at entry to EXEC only; partial frames never alter them.
REQ-022 EXEC decode on Order[7:4]: F -> ClrAll, E -> adden, D -> init strobe, C -> TrigEN=1, B -> TrigEN=0, A -> SetTrigTime, 9 -> SoftReload; any other -> CmdErr.
REQ-023 Strobe latency: high exactly the cycle after the final byte is accepted, for one cycle.
REQ-024 Byte accepted during EXEC is handled as an IDLE byte (back-to-back frames, zero gap).
REQ-025 Gap timer counts cycles in PAYLOAD/CHECK since last accepted byte; at TIMEOUT -> IDLE and CmdErr pulse; counter width clog2(TIMEOUT+1).
REQ-026 SetInit is combinational OR of the registered init strobe and !Locked.

Reset
REQ-027 CLR=1: state IDLE, Order=0, Data=0, all strobes and CmdErr 0, TrigEN=1, gap timer 0; CLR mid-frame discards the partial frame.
REQ-028 CLR has priority over SYNC and DataValid in the same cycle.

Configuration
REQ-029 CMD_DECODER_CKSUM_EN defined: one extra byte after payload, must equal XOR of opcode and all payload bytes; match -> EXEC, mismatch -> IDLE with CmdErr pulse, Order/Data unchanged.
REQ-030 CMD_DECODER_CKSUM_EN undefined: no CHECK state, frame = opcode + payload only.

Structure
REQ-031 Package la_cmd_pkg holds opcode-nibble constants, state enum, SYNC default.
REQ-032 Sub-module cmd_gap_timer implements the REQ-025 counter (clear, enable, expired).

Verification
REQ-033 PAYLOAD_BYTES=1, bytes E3,05 -> adden=1 one cycle after 05, Order=E3, Data=05.
REQ-034 Bytes B0,00 then C0,00 -> TrigEN 1->0 after first frame, 0->1 after second.
REQ-035 Bytes E3, A5, D0, 00 -> no adden; init strobe after 00, SetInit=1 one cycle; Locked=0 -> SetInit held 1.
REQ-036 Opcode E3 then no byte for TIMEOUT cycles -> CmdErr pulse, state IDLE, Order unchanged.
REQ-037 Macro on: E3,05,E6 -> adden; E3,05,00 -> CmdErr, no adden.
REQ-038 Opcode 70,00 -> CmdErr only; CLR asserted after opcode E3 -> next 05 treated as opcode.
